cpu_bus_bridge: RTL and testbench
=================================

Name: cpu_bus_bridge

Overview:
- Parametrised 6502 bus-slave bridge running in the 96 MHz system domain, between the asynchronous CPU pins and N on-chip peripherals (comms, interrupt controller, later blocks).
- Synchronises phi2, R/W, address and data, and decodes a register window into per-peripheral channels.
- Issues single-cycle read and write strobes, registers the read-return byte, and drives the active-low data buffer enable.
- Replaces ad-hoc per-peripheral send_out muxing with a scalable channel fabric.

Parameters:
- NUM_PERIPH, 4, number of peripheral channels (1..8).
- BASE_ADDR, 16'hDF00, first address of the bridge window; must be aligned to NUM_PERIPH*2^REG_BITS.
- REG_BITS, 4, register address bits per channel (16 registers each).
- SYNC_STAGES, 2, synchroniser depth for all CPU inputs (2..3).
- IDLE_BYTE, 8'hAA, byte returned for reads of unpopulated channels.

Ports:
- clk_96mhz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_clk  in  1  raw phi2 from CPU (asynchronous).
- cpu_rwb  in  1  raw R/W (1 = read).
- cpu_addr  in  16  raw address bus.
- cpu_data_in  in  8  raw data bus (write data).
- data_out  out  8  registered read-return byte to the output buffer.
- b_en  out  1  output buffer enable, active-low.
- cs_window  out  1  high while the latched address is inside the window.
- per_addr  out  REG_BITS  latched register offset.
- per_wr_data  out  8  latched write byte.
- per_rd_strobe  out  NUM_PERIPH  one-hot, single-cycle read pulse.
- per_wr_strobe  out  NUM_PERIPH  one-hot, single-cycle write pulse.
- per_rd_data  in  8*NUM_PERIPH  channel k occupies bits [8k+7:8k]; must be valid the cycle after its rd_strobe.

Behaviour:
- Reset (asserted low, async): data_out=8'h00, b_en=1, cs_window=0, per_addr=0, per_wr_data=0, all strobes 0, synchronisers cleared, FSM=IDLE. Reset asserted mid-transaction aborts it with no strobe.
- All CPU inputs pass through SYNC_STAGES flops. Edges are detected on synced phi2 against its previous value: rise at cycle R, fall at cycle F.
- Decode at R: hit = synced addr in [BASE_ADDR, BASE_ADDR + NUM_PERIPH*2^REG_BITS). sel = (addr - BASE_ADDR) >> REG_BITS. Latch per_addr = addr[REG_BITS-1:0]. cs_window = hit from R+1 until the cycle after F.
- FSM states: IDLE, RD_STROBE, RD_HOLD, WR_WAIT, WR_STROBE.
- IDLE:
  - rise & hit & rwb=1 → RD_STROBE.
  - rise & hit & rwb=0 → WR_WAIT.
  - rise & !hit → stay in IDLE; no outputs change.
- RD_STROBE (cycle R+1): per_rd_strobe[sel]=1 for exactly this cycle. Unpopulated sel (>= NUM_PERIPH, not reachable with aligned window): no strobe. → RD_HOLD.
- RD_HOLD entry (R+2): data_out <= per_rd_data[sel]. b_en goes 0 in the same cycle. b_en held 0 and data_out held until fall detected. Cycle after F: b_en=1 → IDLE. data_out retains its last value.
- WR_WAIT: per_wr_data tracks synced data each cycle while phi2 is high. At F, freeze per_wr_data at the value sampled the cycle before F. → WR_STROBE.
- WR_STROBE (F+1): per_wr_strobe[sel]=1 for exactly one cycle → IDLE.
- Short phi2: fall detected while in RD_STROBE. Strobe still issued. data_out still updated at R+2. b_en pulses low for one cycle only (R+2), then IDLE.
- Strobes are one-hot or zero. Read and write strobes are never asserted in the same cycle.
- A new rise while not in IDLE is ignored (cannot occur with legal phi2).
- Latency:
  - Raw phi2 rise to rd_strobe: SYNC_STAGES+2 cycles.
  - rd_strobe to b_en low: 1 cycle.
  - Raw phi2 fall to wr_strobe: SYNC_STAGES+2 cycles.

Test Plan:
- Read ch1 (NUM_PERIPH=4): addr 16'hDF13, rwb=1, per_rd_data ch1=8'h5C → per_rd_strobe=4'b0010 for one cycle, per_addr=3; data_out=8'h5C and b_en=0 one cycle later; b_en=1 the cycle after phi2 fall detect.
- Write ch3: addr 16'hDF3A, rwb=0, data 8'hC3 stable before phi2 fall → one-cycle per_wr_strobe=4'b1000 at F+1, per_addr=4'hA, per_wr_data=8'hC3; no rd_strobe.
- Out-of-window access at 16'hDE00 and 16'hDF40, read and write → no strobes, b_en stays 1, cs_window=0, data_out unchanged.
- Back-to-back 1 MHz read ch0 then write ch2 → exactly one strobe each, correct one-hot, b_en high between cycles.
- Async reset pulsed low mid-RD_HOLD → b_en=1 and data_out=8'h00 immediately, no strobes; next phi2 read completes normally.
- Short phi2 (high for 2 sysclk cycles), read ch2 → rd_strobe issued, b_en low for exactly one cycle, FSM returns to IDLE.

Source files
------------

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: 6502 bus-slave bridge in the 96 MHz system domain.
// Synchronises the raw CPU pins, decodes a register window into
// NUM_PERIPH channels, issues single-cycle read/write strobes, registers the
// read-return byte and drives the active-low output buffer enable.
module cpu_bus_bridge #(
  parameter int unsigned NUM_PERIPH  = 4,
  parameter logic [15:0] BASE_ADDR   = 16'hDF00,
  parameter int unsigned REG_BITS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hAA
) (
  input  logic                    clk_96mhz,
  input  logic                    reset,
  input  logic                    cpu_clk,
  input  logic                    cpu_rwb,
  input  logic [15:0]             cpu_addr,
  input  logic [7:0]              cpu_data_in,
  output logic [7:0]              data_out,
  output logic                    b_en,
  output logic                    cs_window,
  output logic [REG_BITS-1:0]     per_addr,
  output logic [7:0]              per_wr_data,
  output logic [NUM_PERIPH-1:0]   per_rd_strobe,
  output logic [NUM_PERIPH-1:0]   per_wr_strobe,
  input  logic [8*NUM_PERIPH-1:0] per_rd_data
);

  // phi2, R/W, address and data travel through the synchroniser as one bus
  localparam int unsigned SW       = 26;
  localparam logic [16:0] WIN_SIZE = 17'(NUM_PERIPH << REG_BITS);

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    RD_HOLD,
    WR_WAIT,
    WR_STROBE
  } state_t;

  logic [SW-1:0]         sync_q [SYNC_STAGES];
  logic [SW-1:0]         sync_bus;
  logic                  phi2_d;
  logic                  rise_q;
  logic                  fall_q;
  logic                  rwb_q;
  logic [15:0]           addr_q;
  logic [7:0]            data_q;
  logic [16:0]           offset;
  logic                  hit;
  logic [3:0]            sel_now;
  logic [3:0]            sel_r;
  logic [NUM_PERIPH-1:0] rd_onehot;
  logic [NUM_PERIPH-1:0] sel_onehot;
  logic [7:0]            rd_byte;
  logic                  fall_seen;
  state_t                state;

  // Multi-stage synchroniser for every CPU input
  always_ff @(posedge clk_96mhz or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {cpu_clk, cpu_rwb, cpu_addr, cpu_data_in};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_bus = sync_q[SYNC_STAGES-1];

  // Registered phi2 edge detect; bus fields delayed alongside so they line up
  always_ff @(posedge clk_96mhz or negedge reset) begin
    if (!reset) begin
      phi2_d <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      rwb_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      phi2_d <= sync_bus[25];
      rise_q <= sync_bus[25] & ~phi2_d;
      fall_q <= ~sync_bus[25] & phi2_d;
      rwb_q  <= sync_bus[24];
      addr_q <= sync_bus[23:8];
      data_q <= sync_bus[7:0];
    end
  end

  // Window decode: borrow bit flags addresses below the base
  always_comb begin
    offset  = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    hit     = !offset[16] && (offset < WIN_SIZE);
    sel_now = 4'(offset >> REG_BITS);
  end

  // Channel one-hots and read-return mux; unpopulated channels return IDLE_BYTE
  always_comb begin
    rd_onehot  = '0;
    sel_onehot = '0;
    rd_byte    = IDLE_BYTE;
    for (int unsigned k = 0; k < NUM_PERIPH; k++) begin
      if (sel_now == 4'(k)) rd_onehot[k] = 1'b1;
      if (sel_r == 4'(k)) begin
        sel_onehot[k] = 1'b1;
        rd_byte       = per_rd_data[8*k +: 8];
      end
    end
  end

  // Transaction FSM with registered strobes, buffer enable and latched fields
  always_ff @(posedge clk_96mhz or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      data_out      <= 8'h00;
      b_en          <= 1'b1;
      cs_window     <= 1'b0;
      per_addr      <= '0;
      per_wr_data   <= 8'h00;
      per_rd_strobe <= '0;
      per_wr_strobe <= '0;
      sel_r         <= '0;
      fall_seen     <= 1'b0;
    end else begin
      per_rd_strobe <= '0;
      per_wr_strobe <= '0;
      if (fall_q) cs_window <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_q && hit) begin
            per_addr  <= addr_q[REG_BITS-1:0];
            sel_r     <= sel_now;
            cs_window <= 1'b1;
            fall_seen <= 1'b0;
            if (rwb_q) begin
              per_rd_strobe <= rd_onehot;
              state         <= RD_STROBE;
            end else begin
              per_wr_data <= data_q;
              state       <= WR_WAIT;
            end
          end
        end
        RD_STROBE: begin
          // A fall seen here (short phi2) is remembered so RD_HOLD lasts one cycle
          data_out  <= rd_byte;
          b_en      <= 1'b0;
          fall_seen <= fall_q;
          state     <= RD_HOLD;
        end
        RD_HOLD: begin
          if (fall_q || fall_seen) begin
            b_en  <= 1'b1;
            state <= IDLE;
          end
        end
        WR_WAIT: begin
          if (fall_q) begin
            per_wr_strobe <= sel_onehot;
            state         <= WR_STROBE;
          end else begin
            per_wr_data <= data_q;
          end
        end
        WR_STROBE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb_cpu_bus_bridge: randomized and directed bus cycles checked every cycle
// against a latency-rule model of the bridge, plus literal spot checks.
module tb_cpu_bus_bridge;

  localparam int unsigned NP   = 4;
  localparam logic [15:0] BASE = 16'hDF00;
  localparam int unsigned RB   = 4;
  localparam int          S_ST = 2;

  logic        clk_96mhz = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_clk = 1'b0;
  logic        cpu_rwb = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_in = 8'h00;
  logic [7:0]  data_out;
  logic        b_en;
  logic        cs_window;
  logic [3:0]  per_addr;
  logic [7:0]  per_wr_data;
  logic [3:0]  per_rd_strobe;
  logic [3:0]  per_wr_strobe;
  logic [31:0] per_rd_data = 32'h0;

  cpu_bus_bridge #(
    .NUM_PERIPH (NP),
    .BASE_ADDR  (BASE),
    .REG_BITS   (RB),
    .SYNC_STAGES(S_ST),
    .IDLE_BYTE  (8'hAA)
  ) dut (
    .clk_96mhz    (clk_96mhz),
    .reset        (reset),
    .cpu_clk      (cpu_clk),
    .cpu_rwb      (cpu_rwb),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .data_out     (data_out),
    .b_en         (b_en),
    .cs_window    (cs_window),
    .per_addr     (per_addr),
    .per_wr_data  (per_wr_data),
    .per_rd_strobe(per_rd_strobe),
    .per_wr_strobe(per_wr_strobe),
    .per_rd_data  (per_rd_data)
  );

  always #5 clk_96mhz = ~clk_96mhz;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  bit chk_en = 1'b0;

  // Model: expected output changes keyed by the cycle they become visible
  logic [7:0] dout_chg  [int];
  logic [3:0] paddr_chg [int];
  logic [7:0] wdata_chg [int];
  logic [3:0] rds_at    [int];
  logic [3:0] wrs_at    [int];
  bit         ben_low   [int];
  bit         cs_hi     [int];
  logic [7:0] e_dout  = 8'h00;
  logic [3:0] e_paddr = 4'h0;
  logic [7:0] e_wdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Phi2 driven high at cycle n and low at cycle m; outputs follow by fixed latencies
  function automatic void schedule(input int n, input int m, input logic [15:0] a,
                                   input logic rw, input logic [7:0] d, input logic [31:0] rb);
    int off, sel, r1, last;
    off = int'(a) - int'(BASE);
    if (off < 0 || off >= int'(NP * (2 ** RB))) return;
    sel = off / (2 ** RB);
    r1  = n + S_ST + 2;
    paddr_chg[r1] = 4'(off % (2 ** RB));
    for (int t = r1; t <= m + S_ST + 1; t++) cs_hi[t] = 1'b1;
    if (rw) begin
      rds_at[r1]     = 4'(1 << sel);
      dout_chg[r1+1] = 8'(rb >> (8 * sel));
      last = (m + S_ST + 1 > r1 + 1) ? m + S_ST + 1 : r1 + 1;
      for (int t = r1 + 1; t <= last; t++) ben_low[t] = 1'b1;
    end else begin
      wdata_chg[r1]        = d;
      wrs_at[m + S_ST + 2] = 4'(1 << sel);
    end
  endfunction

  function automatic void clear_model();
    dout_chg.delete();
    paddr_chg.delete();
    wdata_chg.delete();
    rds_at.delete();
    wrs_at.delete();
    ben_low.delete();
    cs_hi.delete();
    e_dout  = 8'h00;
    e_paddr = 4'h0;
    e_wdata = 8'h00;
  endfunction

  initial forever begin
    @(posedge clk_96mhz);
    cyc++;
  end

  initial forever begin
    @(negedge clk_96mhz);
    if (|per_rd_strobe) rd_pulses++;
    if (|per_wr_strobe) wr_pulses++;
  end

  // Every-cycle comparison of the DUT against the model
  initial forever begin
    @(negedge clk_96mhz);
    if (chk_en) begin
      if (dout_chg.exists(cyc))  e_dout  = dout_chg[cyc];
      if (paddr_chg.exists(cyc)) e_paddr = paddr_chg[cyc];
      if (wdata_chg.exists(cyc)) e_wdata = wdata_chg[cyc];
      chk("data_out",    32'(data_out),    32'(e_dout));
      chk("b_en",        32'(b_en),        ben_low.exists(cyc) ? 32'd0 : 32'd1);
      chk("cs_window",   32'(cs_window),   cs_hi.exists(cyc) ? 32'd1 : 32'd0);
      chk("per_addr",    32'(per_addr),    32'(e_paddr));
      chk("per_wr_data", 32'(per_wr_data), 32'(e_wdata));
      chk("rd_strobe",   32'(per_rd_strobe), rds_at.exists(cyc) ? 32'(rds_at[cyc]) : 32'd0);
      chk("wr_strobe",   32'(per_wr_strobe), wrs_at.exists(cyc) ? 32'(wrs_at[cyc]) : 32'd0);
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk_96mhz);
      #1;
    end
  endtask

  task automatic at_cycle(input int t);
    do @(negedge clk_96mhz); while (cyc < t);
  endtask

  task automatic run_txn(input logic [15:0] a, input logic rw, input logic [7:0] d,
                         input logic [31:0] rb, input int hi, input int lo);
    int n;
    n = cyc;
    cpu_addr    = a;
    cpu_rwb     = rw;
    cpu_data_in = d;
    per_rd_data = rb;
    cpu_clk     = 1'b1;
    schedule(n, n + hi, a, rw, d, rb);
    idle(hi);
    cpu_clk = 1'b0;
    idle(lo);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, w0, sel;
    logic [31:0] u;
    logic [15:0] a;

    // reset state
    idle(3);
    @(negedge clk_96mhz);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_b_en", 32'(b_en), 32'd1);
    chk("rst_cs", 32'(cs_window), 32'd0);
    chk("rst_per_addr", 32'(per_addr), 32'd0);
    chk("rst_wr_data", 32'(per_wr_data), 32'd0);
    chk("rst_strobes", 32'({per_rd_strobe, per_wr_strobe}), 32'd0);
    @(posedge clk_96mhz);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    idle(4);

    // read ch1
    n = cyc;
    fork
      run_txn(16'hDF13, 1'b1, 8'h00, 32'h4433_5C11, 6, 6);
      begin
        at_cycle(n + S_ST + 2);
        chk("rd1_strobe", 32'(per_rd_strobe), 32'h2);
        chk("rd1_per_addr", 32'(per_addr), 32'h3);
        at_cycle(n + S_ST + 3);
        chk("rd1_data_out", 32'(data_out), 32'h5C);
        chk("rd1_b_en_low", 32'(b_en), 32'd0);
        chk("rd1_strobe_off", 32'(per_rd_strobe), 32'h0);
        at_cycle(n + 6 + S_ST + 1);
        chk("rd1_b_en_hold", 32'(b_en), 32'd0);
        at_cycle(n + 6 + S_ST + 2);
        chk("rd1_b_en_rel", 32'(b_en), 32'd1);
      end
    join

    // write ch3
    n = cyc;
    fork
      run_txn(16'hDF3A, 1'b0, 8'hC3, 32'h0, 6, 6);
      begin
        at_cycle(n + 6 + S_ST + 1);
        chk("wr3_strobe_pre", 32'(per_wr_strobe), 32'h0);
        at_cycle(n + 6 + S_ST + 2);
        chk("wr3_strobe", 32'(per_wr_strobe), 32'h8);
        chk("wr3_per_addr", 32'(per_addr), 32'hA);
        chk("wr3_wr_data", 32'(per_wr_data), 32'hC3);
        chk("wr3_no_rd", 32'(per_rd_strobe), 32'h0);
        at_cycle(n + 6 + S_ST + 3);
        chk("wr3_strobe_post", 32'(per_wr_strobe), 32'h0);
      end
    join

    // out-of-window reads and writes
    r0 = rd_pulses;
    w0 = wr_pulses;
    run_txn(16'hDE00, 1'b1, 8'h12, 32'hFFFF_FFFF, 5, 5);
    run_txn(16'hDE00, 1'b0, 8'h34, 32'hFFFF_FFFF, 5, 5);
    run_txn(16'hDF40, 1'b1, 8'h56, 32'hFFFF_FFFF, 5, 5);
    run_txn(16'hDF40, 1'b0, 8'h78, 32'hFFFF_FFFF, 5, 5);
    @(negedge clk_96mhz);
    chk("oow_rd_pulses", 32'(rd_pulses - r0), 32'd0);
    chk("oow_wr_pulses", 32'(wr_pulses - w0), 32'd0);
    chk("oow_data_out", 32'(data_out), 32'h5C);
    chk("oow_per_addr", 32'(per_addr), 32'hA);
    @(posedge clk_96mhz);
    #1;

    // back-to-back 1 MHz cycles
    r0 = rd_pulses;
    w0 = wr_pulses;
    run_txn(16'hDF05, 1'b1, 8'h00, 32'h0000_0011, 48, 48);
    run_txn(16'hDF27, 1'b0, 8'h7E, 32'h0, 48, 48);
    @(negedge clk_96mhz);
    chk("b2b_rd_pulses", 32'(rd_pulses - r0), 32'd1);
    chk("b2b_wr_pulses", 32'(wr_pulses - w0), 32'd1);
    chk("b2b_data_out", 32'(data_out), 32'h11);
    chk("b2b_wr_data", 32'(per_wr_data), 32'h7E);
    @(posedge clk_96mhz);
    #1;

    // async reset in the middle of a read hold
    n = cyc;
    fork
      run_txn(16'hDF21, 1'b1, 8'h00, 32'h0066_0000, 10, 6);
      begin
        at_cycle(n + S_ST + 5);
        chk("mid_b_en_low", 32'(b_en), 32'd0);
        chk("mid_data_out", 32'(data_out), 32'h66);
        chk_en = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("arst_b_en", 32'(b_en), 32'd1);
        chk("arst_data_out", 32'(data_out), 32'h00);
        chk("arst_cs", 32'(cs_window), 32'd0);
        chk("arst_strobes", 32'({per_rd_strobe, per_wr_strobe}), 32'd0);
      end
    join
    clear_model();
    reset  = 1'b1;
    chk_en = 1'b1;
    idle(3);
    n = cyc;
    fork
      run_txn(16'hDF21, 1'b1, 8'h00, 32'h0077_0000, 6, 6);
      begin
        at_cycle(n + S_ST + 2);
        chk("post_rst_strobe", 32'(per_rd_strobe), 32'h4);
        at_cycle(n + S_ST + 3);
        chk("post_rst_data", 32'(data_out), 32'h77);
      end
    join

    // short phi2 read of ch2
    n = cyc;
    fork
      run_txn(16'hDF2F, 1'b1, 8'h00, 32'h0096_0000, 2, 6);
      begin
        at_cycle(n + S_ST + 2);
        chk("short_strobe", 32'(per_rd_strobe), 32'h4);
        at_cycle(n + S_ST + 3);
        chk("short_b_en_low", 32'(b_en), 32'd0);
        chk("short_data", 32'(data_out), 32'h96);
        at_cycle(n + S_ST + 4);
        chk("short_b_en_rel", 32'(b_en), 32'd1);
      end
    join

    // random traffic
    for (int i = 0; i < 200; i++) begin
      u = $urandom();
      if ($urandom_range(0, 9) < 7) begin
        a = BASE + 16'($urandom_range(0, 63));
      end else begin
        sel = int'($urandom_range(0, 2));
        if (sel == 0)      a = 16'hDE00 + 16'($urandom_range(0, 255));
        else if (sel == 1) a = 16'hDF40 + 16'($urandom_range(0, 191));
        else               a = u[15:0];
      end
      run_txn(a, 1'($urandom_range(0, 1)), 8'($urandom()), $urandom(),
              int'($urandom_range(1, 8)), int'($urandom_range(4, 8)));
    end

    idle(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
